// File: rtl/snake_game_ctrl.sv
// Snake game controller: IDLE/PLAY/PAUSE/OVER sequencing, level-scaled move tick, lives and BCD high score.
// Define SNAKE_PAUSE_EN to build the pause feature; without it I_pause is ignored and PAUSE is unreachable.
module snake_game_ctrl #(
  parameter int SPEED_0     = 20000000,
  parameter int SPEED_STEP  = 3000000,
  parameter int START_LIVES = 3,
  parameter int OVER_HOLD   = 50000000
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_start,
  input  logic       I_pause,
  input  logic       I_dead,
  input  logic [7:0] I_score,
  output logic       O_tick,
  output logic       O_clr,
  output logic       O_run,
  output logic [1:0] O_state,
  output logic [1:0] O_level,
  output logic [1:0] O_lives,
  output logic [7:0] O_high_score
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int CNT_W = (SPEED_0 > 1) ? $clog2(SPEED_0 + 1) : 1;
  localparam int OVR_W = (OVER_HOLD > 1) ? $clog2(OVER_HOLD + 1) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [OVR_W-1:0] over_cnt_q, over_cnt_d;
  logic [1:0]       lives_q, lives_d;
  logic [1:0]       level_q, level_d;
  logic [7:0]       high_q, high_d;
  logic             tick_q, tick_d;
  logic             clr_q, clr_d;
  logic             run_q, run_d;
  logic             start_prev_q;
  logic             start_edge;
  logic             pause_edge;
  logic [31:0]      period;
  logic [31:0]      period_m1;
  logic             tick_due;

  assign start_edge = I_start & ~start_prev_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) start_prev_q <= 1'b0;
    else          start_prev_q <= I_start;
  end

`ifdef SNAKE_PAUSE_EN
  logic pause_prev_q;

  assign pause_edge = I_pause & ~pause_prev_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) pause_prev_q <= 1'b0;
    else          pause_prev_q <= I_pause;
  end
`else
  logic unused_pause;

  assign pause_edge   = 1'b0;
  assign unused_pause = I_pause;
`endif

  // Period follows the registered level, so a level change shortens the very next compare.
  assign period    = 32'(SPEED_0) - 32'(level_q) * 32'(SPEED_STEP);
  assign period_m1 = period - 32'd1;
  assign tick_due  = (32'(tick_cnt_q) >= period_m1);
  assign level_d   = (I_score[7:4] > 4'd3) ? 2'd3 : I_score[5:4];

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    over_cnt_d = '0;
    lives_d    = lives_q;
    high_d     = high_q;
    tick_d     = 1'b0;
    clr_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        if (start_edge) begin
          state_d = ST_PLAY;
          lives_d = 2'(START_LIVES);
          clr_d   = 1'b1;
        end
      end
      ST_PLAY: begin
        // A death outranks both the pending tick and a same-cycle pause edge.
        if (I_dead) begin
          tick_cnt_d = '0;
          lives_d    = lives_q - 2'd1;
          if (lives_q <= 2'd1) begin
            state_d = ST_OVER;
            if (I_score > high_q) high_d = I_score;
          end
        end else begin
          if (tick_due) begin
            tick_d     = 1'b1;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
          if (pause_edge) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_edge) state_d = ST_PLAY;
      end
      ST_OVER: begin
        tick_cnt_d = '0;
        if (over_cnt_q >= OVR_W'(OVER_HOLD - 1)) state_d = ST_IDLE;
        else                                     over_cnt_d = over_cnt_q + OVR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    run_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      over_cnt_q <= '0;
      lives_q    <= 2'd0;
      level_q    <= 2'd0;
      high_q     <= 8'h00;
      tick_q     <= 1'b0;
      clr_q      <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      over_cnt_q <= over_cnt_d;
      lives_q    <= lives_d;
      level_q    <= level_d;
      high_q     <= high_d;
      tick_q     <= tick_d;
      clr_q      <= clr_d;
      run_q      <= run_d;
    end
  end

  assign O_tick       = tick_q;
  assign O_clr        = clr_q;
  assign O_run        = run_q;
  assign O_state      = state_q;
  assign O_level      = level_q;
  assign O_lives      = lives_q;
  assign O_high_score = high_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios plus random play, compared every cycle to a reference model.
module tb_snake_game_ctrl;

  localparam int SPEED_0     = 10;
  localparam int SPEED_STEP  = 2;
  localparam int START_LIVES = 2;
  localparam int OVER_HOLD   = 5;
`ifdef SNAKE_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       I_clk = 1'b0;
  logic       I_rst_n = 1'b0;
  logic       I_start = 1'b0;
  logic       I_pause = 1'b0;
  logic       I_dead = 1'b0;
  logic [7:0] I_score = 8'h00;
  logic       O_tick, O_clr, O_run;
  logic [1:0] O_state, O_level, O_lives;
  logic [7:0] O_high_score;

  int checks = 0;
  int errors = 0;
  int n;

  // Reference model: game phase, ticks elapsed in the current period, lives, etc.
  int m_phase, m_elapsed, m_over_time, m_lives, m_level, m_hs;
  bit m_tick, m_clr, m_run, m_start_prev, m_pause_prev;

  snake_game_ctrl #(
    .SPEED_0(SPEED_0), .SPEED_STEP(SPEED_STEP),
    .START_LIVES(START_LIVES), .OVER_HOLD(OVER_HOLD)
  ) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_start(I_start), .I_pause(I_pause),
    .I_dead(I_dead), .I_score(I_score), .O_tick(O_tick), .O_clr(O_clr),
    .O_run(O_run), .O_state(O_state), .O_level(O_level), .O_lives(O_lives),
    .O_high_score(O_high_score)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_over_time = 0; m_lives = 0; m_level = 0; m_hs = 0;
    m_tick = 0; m_clr = 0; m_run = 0; m_start_prev = 0; m_pause_prev = 0;
  endtask

  // One clock of game rules, evaluated with the inputs present at the edge.
  task automatic model_step();
    int period, tens, next;
    bit s_edge, p_edge;
    s_edge = I_start && !m_start_prev;
    p_edge = PAUSE_EN && I_pause && !m_pause_prev;
    period = SPEED_0 - m_level * SPEED_STEP;
    m_tick = 0;
    m_clr  = 0;
    next   = m_phase;
    if (m_phase == 0) begin
      m_elapsed = 0;
      if (s_edge) begin next = 1; m_lives = START_LIVES; m_clr = 1; end
    end else if (m_phase == 1) begin
      if (I_dead) begin
        m_elapsed = 0;
        m_lives   = m_lives - 1;
        if (m_lives == 0) begin
          next = 3;
          m_over_time = 0;
          if (int'(I_score) > m_hs) m_hs = int'(I_score);
        end
      end else begin
        if (m_elapsed + 1 >= period) begin m_tick = 1; m_elapsed = 0; end
        else m_elapsed = m_elapsed + 1;
        if (p_edge) next = 2;
      end
    end else if (m_phase == 2) begin
      if (p_edge) next = 1;
    end else begin
      m_elapsed = 0;
      m_over_time = m_over_time + 1;
      if (m_over_time >= OVER_HOLD) begin next = 0; m_over_time = 0; end
    end
    m_phase = next;
    m_run   = (next == 1);
    tens    = int'(I_score[7:4]);
    m_level = (tens > 3) ? 3 : tens;
    m_start_prev = I_start;
    m_pause_prev = I_pause;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".state"}, 32'(O_state), 32'(m_phase));
    chk({ctx, ".tick"},  32'(O_tick),  32'(m_tick));
    chk({ctx, ".clr"},   32'(O_clr),   32'(m_clr));
    chk({ctx, ".run"},   32'(O_run),   32'(m_run));
    chk({ctx, ".level"}, 32'(O_level), 32'(m_level));
    chk({ctx, ".lives"}, 32'(O_lives), 32'(m_lives));
    chk({ctx, ".hs"},    32'(O_high_score), 32'(m_hs));
  endtask

  task automatic step(input string ctx);
    @(posedge I_clk);
    model_step();
    #1;
    check_all(ctx);
  endtask

  // Clocks until the next O_tick, bounded.
  task automatic wait_tick(input string ctx, output int cnt);
    cnt = 0;
    do begin
      step(ctx);
      cnt++;
    end while (O_tick !== 1'b1 && cnt < 100);
    if (O_tick !== 1'b1) chk({ctx, ".tick_timeout"}, 32'(O_tick), 32'd1);
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset.state", 32'(O_state), 32'd0);
    chk("reset.tick",  32'(O_tick),  32'd0);
    chk("reset.clr",   32'(O_clr),   32'd0);
    chk("reset.lives", 32'(O_lives), 32'd0);
    chk("reset.hs",    32'(O_high_score), 32'd0);
    @(posedge I_clk); #1;
    I_rst_n = 1'b1;
    step("idle");

    // Start edge, then ticks every 10 clocks with start held high.
    I_start = 1'b1;
    step("start");
    chk("start.clr_pulse", 32'(O_clr), 32'd1);
    chk("start.state", 32'(O_state), 32'd1);
    chk("start.lives", 32'(O_lives), 32'd2);
    step("start2");
    chk("start.clr_once", 32'(O_clr), 32'd0);
    wait_tick("first_tick", n);
    chk("first_tick.gap", 32'(n), 32'd9);
    wait_tick("second_tick", n);
    chk("second_tick.gap", 32'(n), 32'd10);
    I_start = 1'b0;

    // Level 2 from score 0x25 gives a period of 6.
    I_score = 8'h25;
    step("level");
    chk("level.value", 32'(O_level), 32'd2);
    wait_tick("level_t1", n);
    wait_tick("level_t2", n);
    chk("level.gap", 32'(n), 32'd6);

    I_score = 8'h00;
    step("level0");
    wait_tick("pre_pause", n);
    if (PAUSE_EN) begin
      for (int i = 0; i < 3; i++) step("count");
      I_pause = 1'b1;
      step("pause");
      chk("pause.state", 32'(O_state), 32'd2);
      for (int i = 0; i < 20; i++) begin
        if (i == 5) I_pause = 1'b0;
        step("paused");
        chk("paused.no_tick", 32'(O_tick), 32'd0);
      end
      I_pause = 1'b1;
      step("resume");
      chk("resume.state", 32'(O_state), 32'd1);
      wait_tick("resume_tick", n);
      chk("resume.gap", 32'(n), 32'd6);
      I_pause = 1'b0;
    end

    // Two deaths end the game; score 0x12 becomes the high score.
    I_score = 8'h12;
    step("score12");
    I_dead = 1'b1; step("dead1"); I_dead = 1'b0;
    chk("dead1.lives", 32'(O_lives), 32'd1);
    chk("dead1.state", 32'(O_state), 32'd1);
    I_dead = 1'b1; step("dead2"); I_dead = 1'b0;
    chk("dead2.lives", 32'(O_lives), 32'd0);
    chk("dead2.state", 32'(O_state), 32'd3);
    chk("dead2.hs", 32'(O_high_score), 32'h12);
    I_start = 1'b1;
    for (int i = 0; i < 4; i++) step("over_hold");
    chk("over.still", 32'(O_state), 32'd3);
    I_start = 1'b0;
    step("over_end");
    chk("over.idle", 32'(O_state), 32'd0);

    // Death on the tick-due cycle together with a pause edge.
    I_score = 8'h00;
    step("idle2");
    I_start = 1'b1;
    step("start2");
    for (int i = 0; i < 9; i++) step("count9");
    I_dead = 1'b1; I_pause = 1'b1;
    step("dead_tick");
    chk("dead_tick.no_tick", 32'(O_tick), 32'd0);
    chk("dead_tick.state", 32'(O_state), 32'd1);
    chk("dead_tick.lives", 32'(O_lives), 32'd1);
    I_dead = 1'b0; I_pause = 1'b0; I_start = 1'b0;
    step("after_dead");

    // Reset while paused (or playing when pause is not built).
    I_pause = 1'b1; step("to_pause"); I_pause = 1'b0; step("paused2");
    chk("pre_reset.state", 32'(O_state), PAUSE_EN ? 32'd2 : 32'd1);
    I_rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge I_clk); #1;
    I_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_reset");

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) I_start = ~I_start;
      if ($urandom_range(0, 5) == 0) I_pause = ~I_pause;
      I_dead = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 29) == 0)
        I_score = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      step("rand");
    end
    I_dead = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
